// File: rtl/k054539_extbus_arb.sv
// K054539 external bus arbiter: PCM / reverb / host share one ROM+RAM bus.
// Optional macro K054539_EXTBUS_WAIT_EN stretches STROBE to two cycles.
// Ports: clk_i, res_i (async active-high reset);
//   pcm_req_i/pcm_addr_i -> pcm_ack_o/pcm_rdy_o;
//   rev_req_i/rev_wr_i/rev_addr_i/rev_wdata_i -> rev_ack_o/rev_rdy_o;
//   cpu_req_i/cpu_ram_i/cpu_addr_i -> cpu_ack_o/cpu_rdy_o;
//   rdata_o, ra_o, rd_in_i, rd_out_o, rd_oe_o,
//   rocs_o/rooe_o/racs_o/raoe_o/rawp_o (active low), busy_o.
module k054539_extbus_arb #(
  parameter int RAM_AW = 15
) (
  input  logic              clk_i,
  input  logic              res_i,
  input  logic              pcm_req_i,
  input  logic [23:0]       pcm_addr_i,
  output logic              pcm_ack_o,
  output logic              pcm_rdy_o,
  input  logic              rev_req_i,
  input  logic              rev_wr_i,
  input  logic [RAM_AW-1:0] rev_addr_i,
  input  logic [7:0]        rev_wdata_i,
  output logic              rev_ack_o,
  output logic              rev_rdy_o,
  input  logic              cpu_req_i,
  input  logic              cpu_ram_i,
  input  logic [23:0]       cpu_addr_i,
  output logic              cpu_ack_o,
  output logic              cpu_rdy_o,
  output logic [7:0]        rdata_o,
  output logic [23:0]       ra_o,
  input  logic [7:0]        rd_in_i,
  output logic [7:0]        rd_out_o,
  output logic              rd_oe_o,
  output logic              rocs_o,
  output logic              rooe_o,
  output logic              racs_o,
  output logic              raoe_o,
  output logic              rawp_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    LATCH
  } state_t;

  typedef enum logic [1:0] {
    OWN_PCM,
    OWN_REV,
    OWN_CPU
  } own_t;

  state_t      state_q;
  own_t        own_q;
  logic        wr_q;
  logic        ram_q;
  logic        ptr_q;
  logic [23:0] ra_q;
  logic [7:0]  wdata_q;
  logic [7:0]  rdata_q;
  logic [2:0]  ack_q;
  logic [2:0]  rdy_q;
  logic        rocs_q;
  logic        rooe_q;
  logic        racs_q;
  logic        raoe_q;
  logic        rawp_q;
  logic        rd_oe_q;
`ifdef K054539_EXTBUS_WAIT_EN
  logic        stb_q;
`endif

  logic        gnt_d;
  own_t        own_d;
  logic [23:0] addr_d;
  logic        wr_d;
  logic        ram_d;
  logic [7:0]  wdata_d;

  function automatic logic [23:0] zext_ram(
    input logic [RAM_AW-1:0] a
  );
    logic [23:0] r;
    r = '0;
    r[RAM_AW-1:0] = a;
    return r;
  endfunction

  // one-hot {pcm, rev, cpu}
  function automatic logic [2:0] own_vec(input own_t o);
    logic [2:0] v;
    v = 3'b000;
    case (o)
      OWN_PCM: v = 3'b100;
      OWN_REV: v = 3'b010;
      OWN_CPU: v = 3'b001;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

  // PCM always wins; ptr_q=0 favours REV, 1 favours CPU
  always_comb begin
    gnt_d   = 1'b0;
    own_d   = OWN_PCM;
    addr_d  = '0;
    wr_d    = 1'b0;
    ram_d   = 1'b0;
    wdata_d = '0;
    if (pcm_req_i) begin
      gnt_d  = 1'b1;
      own_d  = OWN_PCM;
      addr_d = pcm_addr_i;
    end else if (rev_req_i && (!ptr_q || !cpu_req_i)) begin
      gnt_d   = 1'b1;
      own_d   = OWN_REV;
      addr_d  = zext_ram(rev_addr_i);
      wr_d    = rev_wr_i;
      ram_d   = 1'b1;
      wdata_d = rev_wdata_i;
    end else if (cpu_req_i) begin
      gnt_d  = 1'b1;
      own_d  = OWN_CPU;
      ram_d  = cpu_ram_i;
      addr_d = cpu_ram_i ? zext_ram(cpu_addr_i[RAM_AW-1:0])
                         : cpu_addr_i;
    end
  end

  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      state_q <= IDLE;
      own_q   <= OWN_PCM;
      wr_q    <= 1'b0;
      ram_q   <= 1'b0;
      ptr_q   <= 1'b0;
      ra_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
      rdy_q   <= '0;
      rocs_q  <= 1'b1;
      rooe_q  <= 1'b1;
      racs_q  <= 1'b1;
      raoe_q  <= 1'b1;
      rawp_q  <= 1'b1;
      rd_oe_q <= 1'b0;
`ifdef K054539_EXTBUS_WAIT_EN
      stb_q   <= 1'b0;
`endif
    end else begin
      ack_q <= '0;
      rdy_q <= '0;
      case (state_q)
        IDLE, LATCH: begin
          if (state_q == LATCH) begin
            rdy_q <= own_vec(own_q);
            if (!wr_q) rdata_q <= rd_in_i;
          end
          if (gnt_d) begin
            state_q <= SETUP;
            own_q   <= own_d;
            wr_q    <= wr_d;
            ram_q   <= ram_d;
            ra_q    <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= own_vec(own_d);
            if (own_d != OWN_PCM) ptr_q <= (own_d == OWN_REV);
            // chip select only; OE/WP wait for STROBE
            rocs_q  <= ram_d;
            racs_q  <= !ram_d;
            rooe_q  <= 1'b1;
            raoe_q  <= 1'b1;
            rawp_q  <= 1'b1;
            rd_oe_q <= wr_d;
          end else begin
            state_q <= IDLE;
            rocs_q  <= 1'b1;
            rooe_q  <= 1'b1;
            racs_q  <= 1'b1;
            raoe_q  <= 1'b1;
            rawp_q  <= 1'b1;
            rd_oe_q <= 1'b0;
          end
        end
        SETUP: begin
          state_q <= STROBE;
          rooe_q  <= ram_q | wr_q;
          raoe_q  <= !ram_q | wr_q;
          rawp_q  <= !wr_q;
        end
        STROBE: begin
`ifdef K054539_EXTBUS_WAIT_EN
          if (!stb_q) begin
            stb_q <= 1'b1;
          end else begin
            stb_q   <= 1'b0;
            state_q <= LATCH;
            rawp_q  <= 1'b1;
          end
`else
          state_q <= LATCH;
          rawp_q  <= 1'b1;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pcm_ack_o = ack_q[2];
  assign rev_ack_o = ack_q[1];
  assign cpu_ack_o = ack_q[0];
  assign pcm_rdy_o = rdy_q[2];
  assign rev_rdy_o = rdy_q[1];
  assign cpu_rdy_o = rdy_q[0];
  assign rdata_o   = rdata_q;
  assign ra_o      = ra_q;
  assign rd_out_o  = wdata_q;
  assign rd_oe_o   = rd_oe_q;
  assign rocs_o    = rocs_q;
  assign rooe_o    = rooe_q;
  assign racs_o    = racs_q;
  assign raoe_o    = raoe_q;
  assign rawp_o    = rawp_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_k054539_extbus_arb.sv
// Directed bench for k054539_extbus_arb.
// Inputs change and outputs are sampled on the falling edge.
module tb_k054539_extbus_arb;

`ifdef K054539_EXTBUS_WAIT_EN
  localparam int WS = 2;
`else
  localparam int WS = 1;
`endif
  localparam int L = WS + 2;

  // {rocs, rooe, racs, raoe, rawp, rd_oe}
  localparam logic [31:0] S_IDLE = 32'b111110;
  localparam logic [31:0] S_RO_S = 32'b011110;
  localparam logic [31:0] S_RO_A = 32'b001110;
  localparam logic [31:0] S_WR_S = 32'b110111;
  localparam logic [31:0] S_WR_A = 32'b110101;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcm_req;
  logic [23:0] pcm_addr;
  logic        pcm_ack;
  logic        pcm_rdy;
  logic        rev_req;
  logic        rev_wr;
  logic [14:0] rev_addr;
  logic [7:0]  rev_wdata;
  logic        rev_ack;
  logic        rev_rdy;
  logic        cpu_req;
  logic        cpu_ram;
  logic [23:0] cpu_addr;
  logic        cpu_ack;
  logic        cpu_rdy;
  logic [7:0]  rdata;
  logic [23:0] ra;
  logic [7:0]  rd_in;
  logic [7:0]  rd_out;
  logic        rd_oe;
  logic        rocs;
  logic        rooe;
  logic        racs;
  logic        raoe;
  logic        rawp;
  logic        busy;

  int tests = 0;
  int fails = 0;

  k054539_extbus_arb #(.RAM_AW(15)) dut (
    .clk_i      (clk),
    .res_i      (rst),
    .pcm_req_i  (pcm_req),
    .pcm_addr_i (pcm_addr),
    .pcm_ack_o  (pcm_ack),
    .pcm_rdy_o  (pcm_rdy),
    .rev_req_i  (rev_req),
    .rev_wr_i   (rev_wr),
    .rev_addr_i (rev_addr),
    .rev_wdata_i(rev_wdata),
    .rev_ack_o  (rev_ack),
    .rev_rdy_o  (rev_rdy),
    .cpu_req_i  (cpu_req),
    .cpu_ram_i  (cpu_ram),
    .cpu_addr_i (cpu_addr),
    .cpu_ack_o  (cpu_ack),
    .cpu_rdy_o  (cpu_rdy),
    .rdata_o    (rdata),
    .ra_o       (ra),
    .rd_in_i    (rd_in),
    .rd_out_o   (rd_out),
    .rd_oe_o    (rd_oe),
    .rocs_o     (rocs),
    .rooe_o     (rooe),
    .racs_o     (racs),
    .raoe_o     (raoe),
    .rawp_o     (rawp),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] strb();
    return {26'd0, rocs, rooe, racs, raoe, rawp, rd_oe};
  endfunction

  function automatic logic [31:0] acks();
    return {29'd0, pcm_ack, rev_ack, cpu_ack};
  endfunction

  function automatic logic [31:0] rdys();
    return {29'd0, pcm_rdy, rev_rdy, cpu_rdy};
  endfunction

  logic [31:0] seq [8];
  logic [31:0] ea;
  logic [31:0] er;

  initial begin
    seq = '{32'b010, 32'b001, 32'b010, 32'b001,
            32'b010, 32'b001, 32'b100, 32'b010};
    rst = 1'b1;
    pcm_req = 1'b0; pcm_addr = '0;
    rev_req = 1'b0; rev_wr = 1'b0;
    rev_addr = '0; rev_wdata = '0;
    cpu_req = 1'b0; cpu_ram = 1'b0; cpu_addr = '0;
    rd_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_strb", strb(), S_IDLE);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ra", 32'(ra), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_ack", acks(), 0);
    chk("rst_rdy", rdys(), 0);
    rst = 1'b0;
    @(negedge clk);

    // PCM ROM read
    pcm_req = 1'b1; pcm_addr = 24'h000123; rd_in = 8'h38;
    tick();
    chk("pcm_ack", 32'(pcm_ack), 1);
    chk("pcm_ra", 32'(ra), 32'h123);
    chk("pcm_setup", strb(), S_RO_S);
    chk("pcm_busy", 32'(busy), 1);
    pcm_req = 1'b0;
    for (int i = 0; i < WS; i++) begin
      tick();
      chk("pcm_strobe", strb(), S_RO_A);
      chk("pcm_ack_pulse", 32'(pcm_ack), 0);
    end
    tick();
    chk("pcm_latch", strb(), S_RO_A);
    chk("pcm_rdy_early", 32'(pcm_rdy), 0);
    tick();
    chk("pcm_rdy", 32'(pcm_rdy), 1);
    chk("pcm_rdata", 32'(rdata), 32'h38);
    chk("pcm_idle", strb(), S_IDLE);
    chk("pcm_busy_off", 32'(busy), 0);
    chk("pcm_ra_hold", 32'(ra), 32'h123);
    tick();
    chk("pcm_rdy_pulse", 32'(pcm_rdy), 0);

    // REV RAM write
    rev_req = 1'b1; rev_wr = 1'b1;
    rev_addr = 15'h0050; rev_wdata = 8'h11; rd_in = 8'h99;
    tick();
    chk("rev_ack", 32'(rev_ack), 1);
    chk("rev_ra", 32'(ra), 32'h50);
    chk("rev_setup", strb(), S_WR_S);
    chk("rev_rdout", 32'(rd_out), 32'h11);
    rev_req = 1'b0; rev_wr = 1'b0;
    for (int i = 0; i < WS; i++) begin
      tick();
      chk("rev_strobe", strb(), S_WR_A);
    end
    tick();
    chk("rev_latch", strb(), S_WR_S);
    tick();
    chk("rev_rdy", rdys(), 32'b010);
    chk("rev_rdata_keep", 32'(rdata), 32'h38);
    chk("rev_idle", strb(), S_IDLE);
    tick();
    chk("rev_rdy_pulse", rdys(), 0);

    // CPU ROM read aborted by reset in STROBE
    cpu_req = 1'b1; cpu_ram = 1'b0;
    cpu_addr = 24'h000ABC; rd_in = 8'h5A;
    tick();
    chk("cpu_ack", 32'(cpu_ack), 1);
    chk("cpu_setup", strb(), S_RO_S);
    cpu_req = 1'b0;
    tick();
    chk("cpu_strobe", strb(), S_RO_A);
    rst = 1'b1;
    #1;
    chk("abort_strb", strb(), S_IDLE);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rdata", 32'(rdata), 0);
    chk("abort_ra", 32'(ra), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_rdy", rdys(), 0);
      chk("abort_idle", 32'(busy), 0);
    end
    cpu_req = 1'b1;
    tick();
    chk("recpu_ack", 32'(cpu_ack), 1);
    cpu_req = 1'b0;
    repeat (L - 1) tick();
    chk("recpu_rdy_early", 32'(cpu_rdy), 0);
    tick();
    chk("recpu_rdy", 32'(cpu_rdy), 1);
    chk("recpu_rdata", 32'(rdata), 32'h5A);
    chk("recpu_ra", 32'(ra), 32'hABC);

    // reset pointer, then all three at once
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pcm_req = 1'b1; pcm_addr = 24'h000200;
    rev_req = 1'b1; rev_wr = 1'b0; rev_addr = 15'h0010;
    cpu_req = 1'b1; cpu_ram = 1'b1; cpu_addr = 24'h000020;
    for (int c = 1; c <= 3 * L + 1; c++) begin
      tick();
      ea = (c == 1)         ? 32'b100 :
           (c == 1 + L)     ? 32'b010 :
           (c == 1 + 2 * L) ? 32'b001 : 32'b000;
      er = (c == 1 + L)     ? 32'b100 :
           (c == 1 + 2 * L) ? 32'b010 :
           (c == 1 + 3 * L) ? 32'b001 : 32'b000;
      chk("all3_ack", acks(), ea);
      chk("all3_rdy", rdys(), er);
      chk("all3_busy", 32'(busy), 32'(c <= 3 * L));
      if (c >= 1 + L && c <= 3 * L)
        chk("all3_racs", 32'(racs), 0);
      if (pcm_ack) pcm_req = 1'b0;
      if (rev_ack) rev_req = 1'b0;
      if (cpu_ack) cpu_req = 1'b0;
    end
    pcm_req = 1'b0; rev_req = 1'b0; cpu_req = 1'b0;

    // REV/CPU round-robin, PCM cuts in
    rev_req = 1'b1; cpu_req = 1'b1;
    for (int c = 1; c <= 8 * L + 1; c++) begin
      tick();
      ea = ((c - 1) % L == 0 && (c - 1) / L < 8)
           ? seq[(c - 1) / L] : 32'b000;
      chk("rr_ack", acks(), ea);
      chk("rr_busy", 32'(busy), 32'(c <= 8 * L));
      if (c == 1 + 5 * L) pcm_req = 1'b1;
      if (c == 1 + 6 * L) pcm_req = 1'b0;
      if (c == 1 + 7 * L) begin
        rev_req = 1'b0;
        cpu_req = 1'b0;
      end
    end
    chk("rr_last_rdy", rdys(), 32'b010);

    // CPU withdraws before its grant
    pcm_req = 1'b1; pcm_addr = 24'h000300;
    cpu_req = 1'b1; cpu_ram = 1'b1; cpu_addr = 24'h000040;
    tick();
    chk("wd_pcm_ack", 32'(pcm_ack), 1);
    pcm_req = 1'b0; cpu_req = 1'b0;
    for (int c = 2; c <= L + 3; c++) begin
      tick();
      chk("wd_cpu", {30'd0, cpu_ack, cpu_rdy}, 0);
      chk("wd_busy", 32'(busy), 32'(c <= L));
      if (c == L + 1)
        chk("wd_pcm_rdy", 32'(pcm_rdy), 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/k054539_extbus_arb.md
K054539_EXTBUS_ARB -- requirements
Module: k054539_extbus_arb

Interface
REQ-001 Parameter RAM_AW, default 15: external reverb RAM address width, legal 8..24.
REQ-002 CLK  in  1  master clock; every register updates on its rising edge.
REQ-003 RES  in  1  asynchronous, active-high reset.
REQ-004 PCM_REQ / PCM_ADDR  in  1 / 24  channel sample-fetch request, ROM byte address.
REQ-005 PCM_ACK / PCM_RDY  out  1 / 1  grant pulse / read-complete pulse.
REQ-006 REV_REQ / REV_WR / REV_ADDR / REV_WDATA  in  1 / 1 / RAM_AW / 8  reverb RAM request, write flag, address, write data.
REQ-007 REV_ACK / REV_RDY  out  1 / 1  grant pulse / completion pulse.
REQ-008 CPU_REQ / CPU_RAM / CPU_ADDR  in  1 / 1 / 24  host readout request; CPU_RAM=1 selects RAM, 0 selects ROM; read only.
REQ-009 CPU_ACK / CPU_RDY  out  1 / 1  grant pulse / read-complete pulse.
REQ-010 RDATA  out  8  byte captured by the last completed read.
REQ-011 RA / RD_IN / RD_OUT / RD_OE  out / in / out / out  24 / 8 / 8 / 1  external address, read data, write data, data-drive enable.
REQ-012 ROCS, ROOE, RACS, RAOE, RAWP  out  1 each  active-low ROM/RAM strobes.
REQ-013 BUSY  out  1  high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have four states: IDLE, SETUP, STROBE, LATCH.
REQ-015 Grant evaluation SHALL happen in IDLE and in LATCH; with a grant the next state is SETUP, otherwise IDLE; SETUP->STROBE->LATCH SHALL be unconditional.
REQ-016 Priority SHALL be PCM first, then REV/CPU round-robin; the pointer flips after each REV or CPU grant and is unaffected by PCM grants.
REQ-017 The grant SHALL pulse the winner's ACK for exactly the first SETUP cycle and capture address, write flag, data and target (ROM/RAM) into registers.
REQ-018 A requester SHALL hold REQ until ACK; REQ deasserted before ACK withdraws the request without side effects; REQ still high after ACK is a new request.
REQ-019 RA SHALL present the captured address from SETUP through LATCH; RAM targets zero-extend to 24 bits; RA holds its value in IDLE.
REQ-020 ROM read: ROCS low in SETUP/STROBE/LATCH, ROOE low in STROBE/LATCH; RACS/RAOE/RAWP high.
REQ-021 RAM read: RACS low in SETUP/STROBE/LATCH, RAOE low in STROBE/LATCH; ROM strobes and RAWP high.
REQ-022 RAM write: RACS low in SETUP/STROBE/LATCH, RAWP low in STROBE only, RD_OE=1 and RD_OUT=captured data in SETUP/STROBE/LATCH.
REQ-023 In IDLE all strobes SHALL be high and RD_OE=0.
REQ-024 Reads SHALL sample RD_IN into RDATA at the rising edge ending LATCH; RDATA holds until the next read.
REQ-025 The owner's RDY SHALL pulse for one cycle in the cycle after LATCH (reads and writes); REQ high in IDLE at edge N gives ACK in cycle N+1 and RDY in cycle N+4.
REQ-026 Back-to-back grants SHALL give one access per 3 cycles with no IDLE gap; the chip select stays low across the boundary if the chip is unchanged.
REQ-027 Simultaneous requests from all three SHALL grant PCM, then REV or CPU per pointer.

Reset
REQ-028 RES SHALL immediately force IDLE, all strobes high, RD_OE=0, all ACK/RDY=0, BUSY=0, RA=0, RDATA=0, pointer favouring REV.
REQ-029 Reset mid-access SHALL abandon the access with no RDY; requesters re-request afterwards.

Configuration
REQ-030 Macro K054539_EXTBUS_WAIT_EN defined: STROBE SHALL last 2 cycles (access 4 cycles, RDY at N+5, RAWP low for 2 cycles); undefined: STROBE lasts 1 cycle as specified above.

Verification
REQ-031 PCM_REQ, PCM_ADDR=0x000123, RD_IN=0x38, IDLE -> ACK at N+1, RA=0x000123, ROCS low 3 cycles, ROOE low 2, PCM_RDY at N+4, RDATA=0x38.
REQ-032 REV write, REV_ADDR=0x0050, REV_WDATA=0x11 -> RACS low 3 cycles, RAWP low 1 cycle (2 with wait macro), RD_OUT=0x11 with RD_OE=1, REV_RDY once, RDATA unchanged.
REQ-033 PCM, REV and CPU requests raised at the same edge, all held -> grant order PCM, REV, CPU; ACKs 3 cycles apart; BUSY high throughout.
REQ-034 REV and CPU held continuously for 6 accesses -> grants alternate REV, CPU, REV...; a PCM_REQ raised mid-run wins the next grant.
REQ-035 RES asserted during STROBE of a CPU ROM read -> strobes high same cycle, no CPU_RDY, RDATA=0; after release, re-request completes normally.
REQ-036 CPU_REQ dropped before ACK while PCM busy -> no CPU_ACK/CPU_RDY, FSM returns to IDLE after PCM access.
